// File: rtl/game_timer_bcd_if.sv
// game_timer_bcd_if: timer control inputs (load/start/pause/tick/inc_time/pen_time) and BCD count/status outputs (count/tc/expired/warn/running)
interface game_timer_bcd_if #(parameter int DIGITS = 2);
  logic load, start, pause, tick, inc_time, pen_time;
  logic [4*DIGITS-1:0] count;
  logic tc, expired, warn, running;
  modport master(output load, start, pause, tick, inc_time, pen_time, input count, tc, expired, warn, running);
  modport slave(input load, start, pause, tick, inc_time, pen_time, output count, tc, expired, warn, running);
endinterface

// File: rtl/game_timer_bcd.sv
// game_timer_bcd: multi-digit BCD round countdown with bonus/penalty, pause and warning (clk, async reset, bus: controls in, count/tc/expired/warn/running out)
module game_timer_bcd #(
  parameter int DIGITS = 2,
  parameter logic [4*DIGITS-1:0] LOAD_VALUE = 8'h99,
  parameter int INC_VALUE = 10,
  parameter int PEN_VALUE = 5,
  parameter int WARN_LEVEL = 10
) (
  input logic clk,
  input logic reset,
  game_timer_bcd_if.slave bus
);
  localparam int MAX = 10 ** DIGITS - 1;
  localparam int W = $clog2(MAX + INC_VALUE + PEN_VALUE + 2);
  localparam logic [W-1:0] MX = W'(MAX);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_e;
  state_e state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic expired_q, expired_d;
  logic [W-1:0] cur, up, dn, nxt;
  function automatic logic [W-1:0] to_bin(input logic [4*DIGITS-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * W'(10) + W'(b[4*i+:4]);
    return r;
  endfunction
  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [W-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic [W-1:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(t % W'(10));
      t = t / W'(10);
    end
    return r;
  endfunction
  always_comb begin
    cur = to_bin(count_q);
    up = cur + (bus.inc_time ? W'(INC_VALUE) : '0);
    dn = (bus.pen_time ? W'(PEN_VALUE) : '0) + W'(state_q == RUN && bus.tick);
    nxt = up <= dn ? '0 : (up - dn > MX ? MX : up - dn);
    state_d = state_q;
    count_d = count_q;
    expired_d = 1'b0;
    if (bus.load) begin
      state_d = IDLE;
      count_d = LOAD_VALUE;
    end else begin
      case (state_q)
        IDLE: state_d = bus.start ? RUN : IDLE;
        RUN, PAUSED: begin
          if (state_q == RUN && bus.pause) state_d = PAUSED;
          else begin
            count_d = to_bcd(nxt);
            state_d = nxt == '0 ? EXPIRED : (bus.pause ? PAUSED : RUN);
            expired_d = nxt == '0;
          end
        end
        default: state_d = EXPIRED;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      count_q <= LOAD_VALUE;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      expired_q <= expired_d;
    end
  assign bus.count = count_q;
  assign bus.tc = count_q == '0;
  assign bus.expired = expired_q;
  assign bus.running = state_q == RUN;
  assign bus.warn = (state_q == RUN || state_q == PAUSED) && cur != '0 && int'(cur) <= WARN_LEVEL;
endmodule

// File: tb/tb_game_timer_bcd.sv
// tb_game_timer_bcd: vector table, corner sequences and randomized model check of game_timer_bcd
module tb_game_timer_bcd;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  game_timer_bcd_if #(.DIGITS(2)) ia();
  game_timer_bcd_if #(.DIGITS(3)) ib();
  game_timer_bcd_if #(.DIGITS(2)) ic();
  game_timer_bcd #(.DIGITS(2), .LOAD_VALUE(8'h30)) dut_a(.clk(clk), .reset(reset), .bus(ia));
  game_timer_bcd #(.DIGITS(3), .LOAD_VALUE(12'h100)) dut_b(.clk(clk), .reset(reset), .bus(ib));
  game_timer_bcd #(.DIGITS(2), .LOAD_VALUE(8'h05)) dut_c(.clk(clk), .reset(reset), .bus(ic));
  typedef struct {
    logic l, s, p, t, i, n;
    logic [7:0] cnt;
    logic tc, ex, wr, rn;
  } vec_t;
  vec_t vq[$];
  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXP} m_e;
  m_e mst;
  int mval;
  bit mex;
  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic void add_vec(input logic l, s, p, t, i, n, input logic [7:0] c, input logic tc, ex, wr, rn);
    vq.push_back('{l, s, p, t, i, n, c, tc, ex, wr, rn});
  endfunction
  task automatic set_a(input logic l, s, p, t, i, n);
    ia.load = l; ia.start = s; ia.pause = p; ia.tick = t; ia.inc_time = i; ia.pen_time = n;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input int c, input int tc, ex, wr, rn);
    chk({tag, ".count"}, int'(ia.count), c);
    chk({tag, ".tc"}, int'(ia.tc), tc);
    chk({tag, ".expired"}, int'(ia.expired), ex);
    chk({tag, ".warn"}, int'(ia.warn), wr);
    chk({tag, ".running"}, int'(ia.running), rn);
  endtask
  task automatic model_step(input bit l, s, p, t, i, n);
    int v;
    mex = 0;
    if (l) begin
      mval = 30;
      mst = M_IDLE;
    end else if (mst == M_IDLE) begin
      if (s) mst = M_RUN;
    end else if (mst == M_RUN && p) mst = M_PAUSED;
    else if (mst != M_EXP) begin
      v = mval + 10 * int'(i) - 5 * int'(n) - ((mst == M_RUN) ? int'(t) : 0);
      mval = v < 0 ? 0 : (v > 99 ? 99 : v);
      mst = mval == 0 ? M_EXP : (p ? M_PAUSED : M_RUN);
      mex = mval == 0;
    end
  endtask
  initial begin
    set_a(0, 0, 0, 0, 0, 0);
    {ib.load, ib.start, ib.pause, ib.tick, ib.inc_time, ib.pen_time} = '0;
    {ic.load, ic.start, ic.pause, ic.tick, ic.inc_time, ic.pen_time} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("rst_a", 'h30, 0, 0, 0, 0);
    chk("rst_b.count", int'(ib.count), 'h100);
    chk("rst_c.count", int'(ic.count), 'h05);
    chk("rst_c.warn", int'(ic.warn), 0);
    reset = 1'b0;
    ic.start = 1'b1;
    step();
    ic.start = 1'b0;
    chk("c_start.running", int'(ic.running), 1);
    chk("c_start.warn", int'(ic.warn), 1);
    add_vec(0, 0, 0, 0, 0, 0, 8'h30, 0, 0, 0, 0);
    add_vec(0, 0, 0, 1, 1, 1, 8'h30, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 8'h30, 0, 0, 0, 1);
    for (int k = 4; k <= 8; k++) add_vec(0, 0, 0, 0, 1, 0, 8'(bcd(k * 10)), 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1, 1, 8'h85, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1, 0, 8'h95, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1, 0, 8'h99, 0, 0, 0, 1);
    add_vec(0, 0, 1, 1, 0, 0, 8'h99, 0, 0, 0, 0);
    add_vec(0, 0, 1, 1, 0, 0, 8'h99, 0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 1, 0, 8'h99, 0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, 1, 8'h94, 0, 0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 0, 8'h94, 0, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0, 0, 8'h93, 0, 0, 0, 1);
    for (int k = 1; k <= 13; k++) add_vec(0, 0, 0, 1, 0, 1, 8'(bcd(93 - 6 * k)), 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) add_vec(0, 0, 0, 1, 0, 0, 8'(bcd(15 - k)), 0, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0, 0, 8'h10, 0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 1, 0, 8'h20, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 1, 8'h15, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 1, 8'h10, 0, 0, 1, 1);
    add_vec(0, 0, 0, 1, 0, 1, 8'h04, 0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 8'h00, 1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    add_vec(0, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 0);
    add_vec(1, 1, 0, 1, 0, 0, 8'h30, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 8'h30, 0, 0, 0, 1);
    add_vec(0, 0, 0, 1, 1, 1, 8'h34, 0, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0, 1, 8'h28, 0, 0, 0, 1);
    add_vec(0, 0, 0, 1, 0, 1, 8'h22, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 1, 8'h17, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 1, 8'h12, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 1, 8'h07, 0, 0, 1, 1);
    add_vec(0, 0, 0, 1, 1, 0, 8'h16, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 0, 0, 8'h30, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 8'h30, 0, 0, 0, 1);
    add_vec(0, 0, 1, 0, 0, 0, 8'h30, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 8'h30, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 0, 0, 8'h30, 0, 0, 0, 0);
    foreach (vq[k]) begin
      set_a(vq[k].l, vq[k].s, vq[k].p, vq[k].t, vq[k].i, vq[k].n);
      step();
      chk_a($sformatf("vec%0d", k), int'(vq[k].cnt), int'(vq[k].tc), int'(vq[k].ex), int'(vq[k].wr), int'(vq[k].rn));
    end
    set_a(0, 1, 0, 0, 0, 0);
    step();
    chk_a("cd_start", 'h30, 0, 0, 0, 1);
    for (int k = 1; k <= 32; k++) begin
      set_a(0, 0, 0, 1, 0, 0);
      step();
      chk_a($sformatf("cd%0d", k), int'(bcd(k >= 30 ? 0 : 30 - k)), int'(k >= 30), int'(k == 30),
            int'(k < 30 && 30 - k <= 10), int'(k < 30));
    end
    set_a(0, 0, 0, 0, 0, 0);
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    chk("b_start.running", int'(ib.running), 1);
    ib.tick = 1'b1;
    step();
    chk("b_borrow.count", int'(ib.count), 'h099);
    ib.load = 1'b1;
    step();
    ib.load = 1'b0;
    ib.tick = 1'b0;
    chk("b_load.count", int'(ib.count), 'h100);
    chk("b_load.running", int'(ib.running), 0);
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    ib.tick = 1'b1;
    step();
    step();
    ib.tick = 1'b0;
    chk("b_run.count", int'(ib.count), 'h098);
    #2 reset = 1'b1;
    #1;
    chk("b_arst.count", int'(ib.count), 'h100);
    chk("b_arst.running", int'(ib.running), 0);
    chk("b_arst.tc", int'(ib.tc), 0);
    chk("b_arst.expired", int'(ib.expired), 0);
    chk("b_arst.warn", int'(ib.warn), 0);
    @(negedge clk) reset = 1'b0;
    step();
    mval = 30;
    mst = M_IDLE;
    mex = 0;
    chk_a("a_arst", 'h30, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      bit l, s, p, t, i, n;
      l = $urandom_range(49) == 0;
      s = $urandom_range(3) == 0;
      p = $urandom_range(4) == 0;
      t = $urandom_range(1) == 0;
      i = $urandom_range(4) == 0;
      n = $urandom_range(3) == 0;
      set_a(l, s, p, t, i, n);
      model_step(l, s, p, t, i, n);
      step();
      chk_a($sformatf("rnd%0d", k), int'(bcd(mval)), int'(mval == 0), int'(mex),
            int'((mst == M_RUN || mst == M_PAUSED) && mval > 0 && mval <= 10), int'(mst == M_RUN));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_timer_bcd.md
# game_timer_bcd

Parametrised multi-digit BCD countdown timer for the game round clock. It replaces the fixed two-digit 99-to-0 timer with configurable digit count, bonus-time add, penalty-time subtract, pause, warning flag and an explicit run-state machine. It sits in the game meta-data logic, is driven by the one-second tick generator and game events, and feeds the score/HUD digit renderers and the game-over controller.

## Interface
Parameters:
- DIGITS, 2, number of BCD digits (1..4); MAX = 10^DIGITS − 1
- LOAD_VALUE, 8'h99, packed BCD start value, 4*DIGITS bits, must be nonzero and each nibble ≤ 9
- INC_VALUE, 10, seconds added per inc_time pulse (binary integer)
- PEN_VALUE, 5, seconds removed per pen_time pulse (binary integer)
- WARN_LEVEL, 10, warn asserts when 0 < value ≤ WARN_LEVEL

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  sync: reload LOAD_VALUE, go to IDLE
- start  in  1  sync: IDLE → RUN
- pause  in  1  level: hold countdown while high
- tick  in  1  one-cycle 1 s enable
- inc_time  in  1  one-cycle bonus pulse
- pen_time  in  1  one-cycle penalty pulse
- count  out  4*DIGITS  packed BCD value, digit 0 in [3:0]
- tc  out  1  count == 0
- expired  out  1  one-cycle pulse on entry to EXPIRED
- warn  out  1  low-time flag
- running  out  1  state == RUN

## Operation
- Decided: one clock; reset is asynchronous and active-high.
- States: IDLE, RUN, PAUSED, EXPIRED. Reset → IDLE, count = LOAD_VALUE.
- Priority per cycle: reset > load > state transition/arithmetic.
- load (any state): count ← LOAD_VALUE, state ← IDLE; start, tick, inc, pen in the same cycle are ignored.
- IDLE: start → RUN (pause ignored when start is taken; RUN then checks pause next cycle). tick, inc_time and pen_time are ignored.
- RUN: pause=1 → PAUSED. Otherwise the arithmetic below is applied, with tick contributing −1.
- PAUSED: pause=0 → RUN. tick is ignored. inc_time and pen_time still apply.
- EXPIRED: holds count = 0. tick, inc, pen, start and pause are ignored. Only load or reset exits.
- Arithmetic (RUN/PAUSED), all in one cycle on the combined delta: v' = clamp(v + INC_VALUE·inc − PEN_VALUE·pen − tick_eff, 0, MAX).
  - Value held as BCD; internal conversion width is ≥ ceil(log2(MAX + INC_VALUE + 1)) bits.
  - Upper bound saturates at all-9s. Lower bound floors at 0, never wraps.
- Any v' = 0 in RUN or PAUSED → EXPIRED; expired = 1 for exactly that transition cycle's following clock (registered, one cycle).
- Outputs:
  - tc = (count == 0).
  - warn = state ∈ {RUN, PAUSED} and 0 < value ≤ WARN_LEVEL.
  - running = (state == RUN).
  - tc, warn and running are combinational from registered state/count.

## Timing
- Reset values: count = LOAD_VALUE, state IDLE, tc 0, expired 0, warn 0, running 0.
- count updates one clock after the qualifying tick/inc/pen/load edge; no extra pipeline.
- start → running high the next cycle. The first tick is honoured in the cycle after start registers.
- expired rises in the same cycle count first reads 0 and clears the following cycle. tc stays high until load or reset.
- Reset asserted mid-run: immediate async return to reset values; no expired pulse.
- inc and pen together: net +INC−PEN applied once; with tick also, net −1 more.

## Test plan
- DIGITS=2, LOAD 8'h30, start, 30 ticks → count steps 0x29…0x00; expired one cycle at 0x00; tc stays 1; running drops.
- count 0x95, inc_time → 0x99 (saturate); count 0x07 with inc_time and tick same cycle → 0x16.
- count 0x03, pen_time → 0x00, EXPIRED entered, expired pulse; a further inc_time → count remains 0x00.
- RUN at 0x20, pause high for 5 ticks → count holds 0x20, running 0; inc_time in PAUSED → 0x30; pause low → ticks resume.
- warn: count 0x11 → tick → 0x10 warn=1; inc_time → 0x20 warn=0; IDLE with LOAD_VALUE 8'h05 → warn=0.
- DIGITS=3, LOAD 12'h100, start, tick → 12'h099 (borrow across two digits); load asserted with tick → 12'h100, IDLE; async reset mid-RUN → LOAD_VALUE, all flags 0.
